bcd_calc_sequencer: RTL and testbench



---
 rtl/bcd_calc_sequencer.sv | 235 +++++++++++++++++++++++
 tb/tb_bcd_calc_sequencer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_calc_sequencer.sv
// Purpose: sequencer for two-digit BCD add/subtract via one shared digit adder; optional result chaining (CALC_CHAIN_EN).
// Latency: equals at edge N -> CALC_LO N+1, CALC_HI N+2, SHOW/done N+3; key effects visible one cycle after strobe.
// Backpressure: none; strobes other than clear are dropped while busy, lower-priority strobes in a cycle are dropped.
module bcd_calc_sequencer (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic [3:0] digit_in,
   input  logic       digit_valid,
   input  logic       op_add,
   input  logic       op_sub,
   input  logic       equals,
   input  logic       clear,
   output logic [3:0] disp_hi,
   output logic [3:0] disp_lo,
   output logic       op_is_sub,
   output logic [3:0] result_hi,
   output logic [3:0] result_lo,
   output logic       flag,
   output logic       busy,
   output logic       done
);

   typedef enum logic [2:0] {
      ENTER_A = 3'd0,
      ENTER_B = 3'd1,
      CALC_LO = 3'd2,
      CALC_HI = 3'd3,
      SHOW    = 3'd4
   } state_t;

   // One winning key event per cycle after priority resolution.
   typedef enum logic [2:0] {
      CMD_NONE   = 3'd0,
      CMD_CLEAR  = 3'd1,
      CMD_EQUALS = 3'd2,
      CMD_OP     = 3'd3,
      CMD_DIGIT  = 3'd4
   } cmd_t;

   state_t     state, state_nx;
   cmd_t       cmd;

   logic [3:0] a_hi, a_lo, b_hi, b_lo;
   logic [3:0] a_hi_nx, a_lo_nx, b_hi_nx, b_lo_nx;
   logic [3:0] res_hi_nx, res_lo_nx;
   logic [3:0] disp_hi_nx, disp_lo_nx;
   logic       carry, carry_nx;
   logic       op_is_sub_nx, flag_nx, busy_nx, done_nx;

   logic       digit_ok;
   logic       op_sel_sub;
   logic [3:0] beff_hi, beff_lo;
   logic [4:0] sum_lo, sum_hi;

   // One-digit BCD adder: {carry_out, digit}; binary sums above 9 get +6 correction.
   function automatic logic [4:0] bcd_add(input logic [3:0] x, input logic [3:0] y, input logic cin);
      logic [4:0] s;
      s = {1'b0, x} + {1'b0, y} + {4'b0000, cin};
      if (s > 5'd9)
         bcd_add = {1'b1, s[3:0] + 4'd6};
      else
         bcd_add = s;
   endfunction

   // Subtraction uses the nine's complement of each B digit plus carry-in on the ones digit.
   assign beff_lo = op_is_sub ? (4'd9 - b_lo) : b_lo;
   assign beff_hi = op_is_sub ? (4'd9 - b_hi) : b_hi;
   assign sum_lo  = bcd_add(a_lo, beff_lo, op_is_sub);
   assign sum_hi  = bcd_add(a_hi, beff_hi, carry);

   // Resolve simultaneous strobes: clear > equals > op > digit; non-BCD digits are not key presses.
   always_comb begin
      cmd        = CMD_NONE;
      digit_ok   = digit_valid && (digit_in <= 4'd9);
      op_sel_sub = op_sub && !op_add;
      if (clear)
         cmd = CMD_CLEAR;
      else if (equals)
         cmd = CMD_EQUALS;
      else if (op_add || op_sub)
         cmd = CMD_OP;
      else if (digit_ok)
         cmd = CMD_DIGIT;
   end

   // Next-state, operand/result datapath and registered-output values.
   always_comb begin
      state_nx     = state;
      a_hi_nx      = a_hi;
      a_lo_nx      = a_lo;
      b_hi_nx      = b_hi;
      b_lo_nx      = b_lo;
      res_hi_nx    = result_hi;
      res_lo_nx    = result_lo;
      carry_nx     = carry;
      op_is_sub_nx = op_is_sub;
      flag_nx      = flag;
      busy_nx      = 1'b0;
      done_nx      = 1'b0;
      disp_hi_nx   = 4'd0;
      disp_lo_nx   = 4'd0;

      case (state)
         ENTER_A: begin
            if (cmd == CMD_OP) begin
               op_is_sub_nx = op_sel_sub;
               b_hi_nx      = 4'd0;
               b_lo_nx      = 4'd0;
               state_nx     = ENTER_B;
            end else if (cmd == CMD_DIGIT) begin
               a_hi_nx = a_lo;
               a_lo_nx = digit_in;
            end
         end
         ENTER_B: begin
            if (cmd == CMD_EQUALS) begin
               state_nx = CALC_LO;
            end else if (cmd == CMD_OP) begin
               op_is_sub_nx = op_sel_sub;
            end else if (cmd == CMD_DIGIT) begin
               b_hi_nx = b_lo;
               b_lo_nx = digit_in;
            end
         end
         CALC_LO: begin
            res_lo_nx = sum_lo[3:0];
            carry_nx  = sum_lo[4];
            state_nx  = CALC_HI;
         end
         CALC_HI: begin
            res_hi_nx = sum_hi[3:0];
            // A missing final carry on subtraction means B > A: the result is the 100's complement.
            flag_nx   = sum_hi[4] ^ op_is_sub;
            state_nx  = SHOW;
         end
         SHOW: begin
            if (cmd == CMD_DIGIT) begin
               a_hi_nx  = 4'd0;
               a_lo_nx  = digit_in;
               b_hi_nx  = 4'd0;
               b_lo_nx  = 4'd0;
               flag_nx  = 1'b0;
               state_nx = ENTER_A;
            end
`ifdef CALC_CHAIN_EN
            else if (cmd == CMD_OP) begin
               // Chaining from an out-of-range result would start from a meaningless operand.
               if (!flag) begin
                  a_hi_nx      = result_hi;
                  a_lo_nx      = result_lo;
                  op_is_sub_nx = op_sel_sub;
                  b_hi_nx      = 4'd0;
                  b_lo_nx      = 4'd0;
                  flag_nx      = 1'b0;
                  state_nx     = ENTER_B;
               end
            end else if (cmd == CMD_EQUALS) begin
               a_hi_nx  = result_hi;
               a_lo_nx  = result_lo;
               state_nx = CALC_LO;
            end
`endif
         end
         default: state_nx = ENTER_A;
      endcase

      // clear overrides everything, including an in-flight calculation.
      if (cmd == CMD_CLEAR) begin
         state_nx     = ENTER_A;
         a_hi_nx      = 4'd0;
         a_lo_nx      = 4'd0;
         b_hi_nx      = 4'd0;
         b_lo_nx      = 4'd0;
         res_hi_nx    = 4'd0;
         res_lo_nx    = 4'd0;
         carry_nx     = 1'b0;
         op_is_sub_nx = 1'b0;
         flag_nx      = 1'b0;
      end

      busy_nx = (state_nx == CALC_LO) || (state_nx == CALC_HI);
      done_nx = (state_nx == SHOW) && (state != SHOW);

      case (state_nx)
         ENTER_A: begin
            disp_hi_nx = a_hi_nx;
            disp_lo_nx = a_lo_nx;
         end
         ENTER_B: begin
            disp_hi_nx = b_hi_nx;
            disp_lo_nx = b_lo_nx;
         end
         default: begin
            disp_hi_nx = res_hi_nx;
            disp_lo_nx = res_lo_nx;
         end
      endcase
   end

   // State and all outputs are registered; synchronous reset.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state     <= ENTER_A;
         a_hi      <= 4'd0;
         a_lo      <= 4'd0;
         b_hi      <= 4'd0;
         b_lo      <= 4'd0;
         result_hi <= 4'd0;
         result_lo <= 4'd0;
         carry     <= 1'b0;
         op_is_sub <= 1'b0;
         flag      <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         disp_hi   <= 4'd0;
         disp_lo   <= 4'd0;
      end else begin
         state     <= state_nx;
         a_hi      <= a_hi_nx;
         a_lo      <= a_lo_nx;
         b_hi      <= b_hi_nx;
         b_lo      <= b_lo_nx;
         result_hi <= res_hi_nx;
         result_lo <= res_lo_nx;
         carry     <= carry_nx;
         op_is_sub <= op_is_sub_nx;
         flag      <= flag_nx;
         busy      <= busy_nx;
         done      <= done_nx;
         disp_hi   <= disp_hi_nx;
         disp_lo   <= disp_lo_nx;
      end
   end

endmodule

// File: tb/tb_bcd_calc_sequencer.sv
// Purpose: self-checking bench for bcd_calc_sequencer: vector table, corner sequences, random keys vs arithmetic model.
// Latency: inputs driven on falling edge, outputs compared on the following falling edge.
// Backpressure: none; every wait is a bounded number of cycles.
module tb_bcd_calc_sequencer;

   logic       CLOCK_50;
   logic       reset;
   logic [3:0] digit_in;
   logic       digit_valid;
   logic       op_add;
   logic       op_sub;
   logic       equals;
   logic       clear;
   logic [3:0] disp_hi;
   logic [3:0] disp_lo;
   logic       op_is_sub;
   logic [3:0] result_hi;
   logic [3:0] result_lo;
   logic       flag;
   logic       busy;
   logic       done;

   int n_chk;
   int n_fail;

   // Behavioural model: operands and result held as plain integers 0..99.
   int m_a, m_b, m_res, m_phase, m_cnt;  // phase: 0 entering A, 1 entering B, 2 computing, 3 showing
   bit m_sub, m_flag, m_done;

   bcd_calc_sequencer dut (
      .CLOCK_50    (CLOCK_50),
      .reset       (reset),
      .digit_in    (digit_in),
      .digit_valid (digit_valid),
      .op_add      (op_add),
      .op_sub      (op_sub),
      .equals      (equals),
      .clear       (clear),
      .disp_hi     (disp_hi),
      .disp_lo     (disp_lo),
      .op_is_sub   (op_is_sub),
      .result_hi   (result_hi),
      .result_lo   (result_lo),
      .flag        (flag),
      .busy        (busy),
      .done        (done)
   );

   initial begin
      CLOCK_50 = 1'b0;
      forever #5 CLOCK_50 = ~CLOCK_50;
   end

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic void m_reset();
      m_a = 0; m_b = 0; m_res = 0; m_phase = 0; m_cnt = 0;
      m_sub = 0; m_flag = 0; m_done = 0;
   endfunction

   function automatic void m_compute();
      int v;
      if (m_sub) begin
         v      = m_a - m_b;
         m_flag = (v < 0);
         m_res  = (v + 100) % 100;
      end else begin
         v      = m_a + m_b;
         m_flag = (v >= 100);
         m_res  = v % 100;
      end
   endfunction

   function automatic void m_step(input logic [3:0] d, input bit dv, input bit oa, input bit os,
                                  input bit eq, input bit cl);
      bit dig_ok;
      dig_ok = dv && (d <= 9);
      m_done = 0;
      if (cl) begin
         m_reset();
      end else if (m_phase == 2) begin
         m_cnt--;
         if (m_cnt == 0) begin
            m_compute();
            m_phase = 3;
            m_done  = 1;
         end
      end else if (eq) begin
         if (m_phase == 1) begin
            m_phase = 2; m_cnt = 2;
         end
`ifdef CALC_CHAIN_EN
         else if (m_phase == 3) begin
            m_a = m_res; m_phase = 2; m_cnt = 2;
         end
`endif
      end else if (oa || os) begin
         if (m_phase == 0) begin
            m_sub = !oa; m_b = 0; m_phase = 1;
         end else if (m_phase == 1) begin
            m_sub = !oa;
         end
`ifdef CALC_CHAIN_EN
         else if (m_phase == 3 && !m_flag) begin
            m_a = m_res; m_sub = !oa; m_b = 0; m_flag = 0; m_phase = 1;
         end
`endif
      end else if (dig_ok) begin
         if (m_phase == 0) m_a = (m_a % 10) * 10 + int'(d);
         else if (m_phase == 1) m_b = (m_b % 10) * 10 + int'(d);
         else if (m_phase == 3) begin
            m_a = int'(d); m_b = 0; m_flag = 0; m_phase = 0;
         end
      end
   endfunction

   task automatic check_model();
      int dv;
      chk("busy", busy, 8'(m_phase == 2));
      chk("done", done, 8'(m_done));
      chk("op_is_sub", op_is_sub, 8'(m_sub));
      chk("flag", flag, 8'(m_flag));
      if (m_phase != 2) begin
         chk("result_hi", result_hi, 8'(m_res / 10));
         chk("result_lo", result_lo, 8'(m_res % 10));
         dv = (m_phase == 0) ? m_a : (m_phase == 1) ? m_b : m_res;
         chk("disp_hi", disp_hi, 8'(dv / 10));
         chk("disp_lo", disp_lo, 8'(dv % 10));
      end
   endtask

   // Called on a falling edge: drive one cycle of strobes, advance, compare on the next falling edge.
   task automatic tk(input logic [3:0] d, input bit dv, input bit oa, input bit os, input bit eq, input bit cl);
      digit_in = d; digit_valid = dv; op_add = oa; op_sub = os; equals = eq; clear = cl;
      m_step(d, dv, oa, os, eq, cl);
      @(negedge CLOCK_50);
      digit_in = 4'd0; digit_valid = 0; op_add = 0; op_sub = 0; equals = 0; clear = 0;
      check_model();
   endtask

   task automatic key(input logic [3:0] d);
      tk(d, 1, 0, 0, 0, 0);
   endtask

   task automatic idle();
      tk(4'd0, 0, 0, 0, 0, 0);
   endtask

   typedef struct {
      logic [3:0] a1, a0, b1, b0;
      bit         sub;
      logic [3:0] ehi, elo;
      bit         eflag;
   } vec_t;

   // Full calculation from a cleared state; checks latency, busy length, result and flag.
   task automatic run_calc(input vec_t v);
      int lat, bc;
      tk(4'd0, 0, 0, 0, 0, 1);
      key(v.a1); key(v.a0);
      tk(4'd0, 0, !v.sub, v.sub, 0, 0);
      key(v.b1); key(v.b0);
      tk(4'd0, 0, 0, 0, 1, 0);
      lat = 0;
      bc  = busy ? 1 : 0;
      for (int k = 1; k <= 6; k++) begin
         idle();
         if (busy) bc++;
         if (done && lat == 0) lat = k + 1;
      end
      chk("done_latency", 8'(lat), 8'd3);
      chk("busy_cycles", 8'(bc), 8'd2);
      chk("vec_result_hi", result_hi, {4'd0, v.ehi});
      chk("vec_result_lo", result_lo, {4'd0, v.elo});
      chk("vec_flag", flag, {7'd0, v.eflag});
   endtask

   vec_t vt[9];

   initial begin
      int ndone;
      bit r_dv, r_oa, r_os, r_eq, r_cl;
      logic [3:0] r_d;

      vt[0] = '{4'd4, 4'd7, 1'b0, 4'd3, 4'd8, 4'd8, 4'd5, 1'b0};
      vt[0] = '{a1: 4'd4, a0: 4'd7, b1: 4'd3, b0: 4'd8, sub: 1'b0, ehi: 4'd8, elo: 4'd5, eflag: 1'b0};
      vt[1] = '{a1: 4'd9, a0: 4'd9, b1: 4'd0, b0: 4'd1, sub: 1'b0, ehi: 4'd0, elo: 4'd0, eflag: 1'b1};
      vt[2] = '{a1: 4'd5, a0: 4'd0, b1: 4'd2, b0: 4'd3, sub: 1'b1, ehi: 4'd2, elo: 4'd7, eflag: 1'b0};
      vt[3] = '{a1: 4'd2, a0: 4'd3, b1: 4'd5, b0: 4'd0, sub: 1'b1, ehi: 4'd7, elo: 4'd3, eflag: 1'b1};
      vt[4] = '{a1: 4'd0, a0: 4'd0, b1: 4'd0, b0: 4'd0, sub: 1'b1, ehi: 4'd0, elo: 4'd0, eflag: 1'b0};
      vt[5] = '{a1: 4'd0, a0: 4'd0, b1: 4'd0, b0: 4'd1, sub: 1'b1, ehi: 4'd9, elo: 4'd9, eflag: 1'b1};
      vt[6] = '{a1: 4'd9, a0: 4'd9, b1: 4'd9, b0: 4'd9, sub: 1'b0, ehi: 4'd9, elo: 4'd8, eflag: 1'b1};
      vt[7] = '{a1: 4'd0, a0: 4'd9, b1: 4'd0, b0: 4'd1, sub: 1'b0, ehi: 4'd1, elo: 4'd0, eflag: 1'b0};
      vt[8] = '{a1: 4'd1, a0: 4'd2, b1: 4'd3, b0: 4'd4, sub: 1'b0, ehi: 4'd4, elo: 4'd6, eflag: 1'b0};

      n_chk = 0; n_fail = 0;
      reset = 1;
      digit_in = 4'd0; digit_valid = 0; op_add = 0; op_sub = 0; equals = 0; clear = 0;
      m_reset();
      @(negedge CLOCK_50);
      @(negedge CLOCK_50);
      chk("rst_disp_hi", disp_hi, 8'd0);
      chk("rst_disp_lo", disp_lo, 8'd0);
      chk("rst_result_hi", result_hi, 8'd0);
      chk("rst_result_lo", result_lo, 8'd0);
      chk("rst_flag", flag, 8'd0);
      chk("rst_busy", busy, 8'd0);
      chk("rst_done", done, 8'd0);
      chk("rst_op_is_sub", op_is_sub, 8'd0);
      reset = 0;

      // Table of complete calculations.
      for (int i = 0; i < 9; i++) run_calc(vt[i]);

      // Non-BCD digit is ignored; older digits shift out of A.
      tk(4'd0, 0, 0, 0, 0, 1);
      key(4'hC);
      chk("bad_digit_hi", disp_hi, 8'd0);
      chk("bad_digit_lo", disp_lo, 8'd0);
      key(4'd1); key(4'd2); key(4'd3);
      chk("shift_a_hi", disp_hi, 8'd2);
      chk("shift_a_lo", disp_lo, 8'd3);

      // Chaining after 12 + 34 = 46.
      run_calc(vt[8]);
      tk(4'd0, 0, 1, 0, 0, 0);
`ifdef CALC_CHAIN_EN
      chk("chain_op_disp_hi", disp_hi, 8'd0);
      chk("chain_op_disp_lo", disp_lo, 8'd0);
`else
      chk("chain_op_disp_hi", disp_hi, 8'd4);
      chk("chain_op_disp_lo", disp_lo, 8'd6);
`endif
      key(4'd1); key(4'd0);
      tk(4'd0, 0, 0, 0, 1, 0);
      for (int k = 0; k < 4; k++) idle();
`ifdef CALC_CHAIN_EN
      chk("chain_result_hi", result_hi, 8'd5);
      chk("chain_result_lo", result_lo, 8'd6);
`else
      chk("chain_result_hi", result_hi, 8'd4);
      chk("chain_result_lo", result_lo, 8'd6);
`endif

      // clear during CALC_LO aborts with no done pulse.
      tk(4'd0, 0, 0, 0, 0, 1);
      key(4'd4); key(4'd7); tk(4'd0, 0, 1, 0, 0, 0); key(4'd3); key(4'd8);
      tk(4'd0, 0, 0, 0, 1, 0);
      chk("abort_in_calc_lo", busy, 8'd1);
      tk(4'd0, 0, 0, 0, 0, 1);
      chk("abort_busy", busy, 8'd0);
      chk("abort_disp_hi", disp_hi, 8'd0);
      chk("abort_disp_lo", disp_lo, 8'd0);
      chk("abort_result_lo", result_lo, 8'd0);
      ndone = 0;
      for (int k = 0; k < 4; k++) begin
         idle();
         if (done) ndone++;
      end
      chk("abort_no_done", 8'(ndone), 8'd0);

      // clear and equals together: clear wins.
      key(4'd1); tk(4'd0, 0, 1, 0, 0, 0); key(4'd2);
      tk(4'd0, 0, 0, 0, 1, 1);
      chk("clear_vs_eq_busy", busy, 8'd0);
      chk("clear_vs_eq_disp_lo", disp_lo, 8'd0);
      idle();
      chk("clear_vs_eq_no_done", done, 8'd0);

      // Random key traffic against the model.
      for (int i = 0; i < 4000; i++) begin
         r_cl = ($urandom_range(0, 99) < 2);
         r_eq = ($urandom_range(0, 99) < 10);
         r_oa = ($urandom_range(0, 99) < 8);
         r_os = ($urandom_range(0, 99) < 8);
         r_dv = ($urandom_range(0, 99) < 40);
         r_d  = 4'($urandom_range(0, 15));
         tk(r_d, r_dv, r_oa, r_os, r_eq, r_cl);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
